// File: rtl/commit_trace_buffer.sv
// Purpose: classify each retired cycle into a trace record, stamp it with an instruction number, buffer it for a valid/ready reader.
// Latency: a record captured at edge N is presented on out_* right after edge N when the buffer was empty.
// Backpressure: out_ready low holds the head record; a push into a full buffer with no same-cycle pop is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   commit_valid .. halt        per-cycle retirement signals from the commit points
//   out_valid/out_ready         head-record handshake; out_kind..out_mdata carry the head record
//   count                       buffer occupancy
//   overflow                    sticky, a record was dropped
//   halted / done               halt record captured / halt record drained
// Optional: define TRACE_CYCLE_STAMP_EN to add out_cycle, the free-running cycle count at each record's capture.
module commit_trace_buffer #(
    parameter int DEPTH  = 8,
    parameter int INUM_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [15:0]              pc,
    input  logic [15:0]              inst,
    input  logic                     reg_write,
    input  logic [2:0]               write_reg,
    input  logic [15:0]              write_data,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [15:0]              mem_addr,
    input  logic [15:0]              mem_data,
    input  logic                     halt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_kind,
    output logic [INUM_W-1:0]        out_inum,
    output logic [15:0]              out_pc,
    output logic [15:0]              out_inst,
    output logic [2:0]               out_reg,
    output logic [15:0]              out_val,
    output logic [15:0]              out_addr,
    output logic [15:0]              out_mdata,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [31:0]              out_cycle,
`endif
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done,
    output logic                     halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] KIND_PLAIN = 3'd0;
    localparam logic [2:0] KIND_REG   = 3'd1;
    localparam logic [2:0] KIND_LOAD  = 3'd2;
    localparam logic [2:0] KIND_STORE = 3'd3;
    localparam logic [2:0] KIND_STU   = 3'd4;
    localparam logic [2:0] KIND_HALT  = 3'd5;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("commit_trace_buffer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]        kind;
        logic [INUM_W-1:0] inum;
        logic [15:0]       pc;
        logic [15:0]       inst;
        logic [2:0]        rd;
        logic [15:0]       val;
        logic [15:0]       addr;
        logic [15:0]       mdata;
`ifdef TRACE_CYCLE_STAMP_EN
        logic [31:0]       cycle;
`endif
    } rec_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [INUM_W-1:0] inum_q, inum_d;
    logic              overflow_q, overflow_d;
    rec_t              mem_q [DEPTH];
    rec_t              mem_d [DEPTH];
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0]       cycle_q, cycle_d;
`endif

    logic       capture;
    logic       pop;
    logic       push_ok;
    logic [2:0] kind;
    rec_t       new_rec;
    rec_t       head;

    // Priority classification: a register write dominates halt, so a halt
    // that also writes a register is logged as REG/LOAD/STU and keeps capture alive.
    always_comb begin
        kind = KIND_PLAIN;
        if (reg_write && mem_write)     kind = KIND_STU;
        else if (reg_write && mem_read) kind = KIND_LOAD;
        else if (reg_write)             kind = KIND_REG;
        else if (halt)                  kind = KIND_HALT;
        else if (mem_write)             kind = KIND_STORE;
    end

    always_comb begin
        new_rec       = '0;
        new_rec.kind  = kind;
        new_rec.inum  = inum_q;
        new_rec.pc    = pc;
        new_rec.inst  = inst;
        new_rec.rd    = write_reg;
        new_rec.val   = write_data;
        new_rec.addr  = mem_addr;
        new_rec.mdata = mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
        new_rec.cycle = cycle_q;
`endif
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0) && (state_q != ST_DONE);
    assign pop       = out_valid && out_ready;
    assign capture   = (state_q == ST_RUN) && commit_valid;
    // A full buffer still takes the record when the head leaves on the same edge.
    assign push_ok   = capture && ((count_q < CW'(DEPTH)) || pop);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inum_d     = inum_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = new_rec;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);

        // The instruction number advances for every captured commit, dropped or not.
        if (capture) begin
            inum_d = inum_q + INUM_W'(1);
            if (!push_ok) overflow_d = 1'b1;
        end

        unique case (state_q)
            ST_RUN:   if (capture && kind == KIND_HALT) state_d = ST_DRAIN;
            ST_DRAIN: if (count_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

`ifdef TRACE_CYCLE_STAMP_EN
    always_comb begin
        cycle_d = cycle_q + 32'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inum_q     <= '0;
            overflow_q <= 1'b0;
`ifdef TRACE_CYCLE_STAMP_EN
            cycle_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inum_q     <= inum_d;
            overflow_q <= overflow_d;
`ifdef TRACE_CYCLE_STAMP_EN
            cycle_q    <= cycle_d;
`endif
        end
    end

    // Record storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_kind  = head.kind;
    assign out_inum  = head.inum;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign out_reg   = head.rd;
    assign out_val   = head.val;
    assign out_addr  = head.addr;
    assign out_mdata = head.mdata;
`ifdef TRACE_CYCLE_STAMP_EN
    assign out_cycle = head.cycle;
`endif
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign halted    = (state_q != ST_RUN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [15:0] pc, inst, write_data, mem_addr, mem_data;
    logic        reg_write, mem_read, mem_write, halt;
    logic [2:0]  write_reg;
    logic        out_valid, out_ready;
    logic [2:0]  out_kind, out_reg;
    logic [15:0] out_inum, out_pc, out_inst, out_val, out_addr, out_mdata;
    logic [3:0]  count;
    logic        overflow, done, halted;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [31:0] out_cycle;
`endif

    commit_trace_buffer #(.DEPTH(DEPTH), .INUM_W(16)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .inst(inst),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_inum(out_inum), .out_pc(out_pc), .out_inst(out_inst),
        .out_reg(out_reg), .out_val(out_val), .out_addr(out_addr), .out_mdata(out_mdata),
`ifdef TRACE_CYCLE_STAMP_EN
        .out_cycle(out_cycle),
`endif
        .count(count), .overflow(overflow), .done(done), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] inum;
        logic [15:0] pc;
        logic [15:0] inst;
        logic [2:0]  rd;
        logic [15:0] val;
        logic [15:0] addr;
        logic [15:0] mdata;
        logic [31:0] cycle;
    } rec_t;

    // Reference model: a list of expected records plus a plain occupancy number.
    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;
    rec_t sb[$];
    int   m_count, m_inum, m_state, m_cycle;
    bit   m_ovf;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] spec_kind();
        if (reg_write && mem_write) return 3'd4;
        if (reg_write && mem_read)  return 3'd2;
        if (reg_write)              return 3'd1;
        if (halt)                   return 3'd5;
        if (mem_write)              return 3'd3;
        return 3'd0;
    endfunction

    // Apply the rules for the edge about to happen, using the inputs now driven.
    task automatic model_edge();
        int   nstate;
        bit   pop;
        rec_t r;
        if (rst) begin
            m_count = 0; m_inum = 0; m_state = M_RUN; m_ovf = 0; m_cycle = 0;
            sb.delete();
            return;
        end
        nstate = m_state;
        pop = (m_count > 0) && out_ready && (m_state != M_DONE);
        if (m_state == M_DRAIN && m_count == 0) nstate = M_DONE;
        if (m_state == M_RUN && commit_valid) begin
            r = '0;
            r.kind = spec_kind(); r.inum = 16'(m_inum); r.pc = pc; r.inst = inst;
            r.rd = write_reg; r.val = write_data; r.addr = mem_addr; r.mdata = mem_data;
`ifdef TRACE_CYCLE_STAMP_EN
            r.cycle = 32'(m_cycle);
`endif
            if (m_count < DEPTH || pop) begin
                sb.push_back(r);
                m_count++;
            end else begin
                m_ovf = 1;
            end
            m_inum = (m_inum + 1) & 16'hFFFF;
            if (r.kind == 3'd5) nstate = M_DRAIN;
        end
        if (pop) m_count--;
        m_state = nstate;
        m_cycle++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("count", 32'(count), 32'(m_count));
        chk("out_valid", 32'(out_valid), 32'(m_count > 0 && m_state != M_DONE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("halted", 32'(halted), 32'(m_state != M_RUN));
        chk("done", 32'(done), 32'(m_state == M_DONE));
    endtask

    task automatic drive(bit cv, bit rw, bit mr, bit mw, bit h, bit rdy);
        commit_valid = cv; reg_write = rw; mem_read = mr; mem_write = mw;
        halt = h; out_ready = rdy;
        pc = 16'($urandom); inst = 16'($urandom); write_reg = 3'($urandom);
        write_data = 16'($urandom); mem_addr = 16'($urandom); mem_data = 16'($urandom);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Monitor: a handshake seen here completes on the coming rising edge.
    initial begin
        rec_t act, exp;
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                act = '0;
                act.kind = out_kind; act.inum = out_inum; act.pc = out_pc; act.inst = out_inst;
                act.rd = out_reg; act.val = out_val; act.addr = out_addr; act.mdata = out_mdata;
`ifdef TRACE_CYCLE_STAMP_EN
                act.cycle = out_cycle;
`endif
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL record: got kind %0d inum %0d, expected no record", act.kind, act.inum);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL record: got %h, expected %h", act, exp);
                    end
                end
            end
        end
    end

    initial begin
        bit got_done;
        do_reset();
        do_reset();

        // REG, STORE, PLAIN
        drive(1, 1, 0, 0, 0, 1); write_reg = 3'd3; write_data = 16'h1234; step();
        drive(1, 0, 0, 1, 0, 1); mem_addr = 16'h0040; mem_data = 16'hBEEF; step();
        drive(1, 0, 0, 0, 0, 1); step();
        // LOAD, then STU with halt also asserted (must not end capture)
        drive(1, 1, 1, 0, 0, 1); mem_addr = 16'h0100; step();
        drive(1, 1, 0, 1, 1, 1); write_reg = 3'd5; mem_addr = 16'h0102; step();
        drive(0, 0, 0, 0, 0, 1); step(); step();
        chk("stu_halt_keeps_run", 32'(halted), 32'd0);

        // Back-pressure and overflow
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
            step();
        end
        chk("full_count", 32'(count), 32'd8);
        chk("full_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end
        drive(1, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        chk("inum_after_drop", 32'(out_inum), 32'd10);
        drive(0, 0, 0, 0, 0, 1); step();

        // Full with same-cycle pop
        do_reset();
        for (int i = 0; i < 8; i++) begin drive(1, 1, 0, 0, 0, 0); step(); end
        drive(1, 0, 0, 1, 0, 1); step();
        chk("full_pop_count", 32'(count), 32'd8);
        chk("full_pop_overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 9; i++) begin drive(0, 0, 0, 0, 0, 1); step(); end

        // Reset mid-run
        for (int i = 0; i < 4; i++) begin drive(1, 1, 0, 0, 0, 0); step(); end
        chk("pre_reset_count", 32'(count), 32'd4);
        do_reset();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        drive(0, 0, 0, 0, 0, 0); step(); step(); step();
        drive(1, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        chk("rst_inum", 32'(out_inum), 32'd0);
`ifdef TRACE_CYCLE_STAMP_EN
        chk("rst_cycle", out_cycle, 32'd3);
`endif
        drive(0, 0, 0, 0, 0, 1); step();

        // Halt flow
        do_reset();
        drive(1, 1, 0, 0, 0, 0); step();
        drive(1, 0, 0, 1, 0, 0); step();
        drive(1, 0, 0, 1, 1, 0); step();
        chk("halted_set", 32'(halted), 32'd1);
        for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0, 0); step(); end
        chk("halt_ignores_commits", 32'(count), 32'd3);
        got_done = 0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            drive(1, 1, 0, 0, 0, 1); step();
            if (done === 1'b1) got_done = 1;
        end
        chk("halt_done", 32'(done), 32'd1);
        chk("halt_done_out_valid", 32'(out_valid), 32'd0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom % 50) == 0, ($urandom % 3) != 0);
            step();
            if (done === 1'b1 && ($urandom % 4) == 0) do_reset();
        end
        drive(1, 0, 0, 0, 1, 1); step();
        got_done = 0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            drive(1'($urandom), 1'($urandom), 0, 0, 1'($urandom), 1); step();
            if (done === 1'b1) got_done = 1;
        end
        chk("final_done", 32'(done), 32'd1);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the processor's commit points (fetch PC/instr, register-file write port, memory-stage access/halt) and consumes the same per-cycle retirement signals the trace bench logs.
- Classifies each committed cycle into a trace record, stamps it with a running instruction number, and buffers it in a FIFO.
- A valid/ready reader drains the FIFO: an on-chip trace port or a bench drainer writing verilogsim.trace.
- Stops capturing after the halt record and reports completion once drained.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
INUM_W, 16, width of the instruction-number counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
commit_valid  in  1  a retirement record is presented this cycle
pc  in  16  PC of committing instruction
inst  in  16  instruction word
reg_write  in  1  register file written
write_reg  in  3  destination register
write_data  in  16  register write data
mem_read  in  1  memory read
mem_write  in  1  memory write
mem_addr  in  16  memory address
mem_data  in  16  memory write data
halt  in  1  halt reached memory/writeback
out_valid  out  1  head record available
out_ready  in  1  reader accepts head record
out_kind  out  3  record kind (encoding below)
out_inum  out  INUM_W  instruction number
out_pc  out  16  PC
out_inst  out  16  instruction word
out_reg  out  3  destination register
out_val  out  16  register write data
out_addr  out  16  memory address
out_mdata  out  16  memory write data
count  out  log2(DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: record dropped because FIFO full
done  out  1  halt record drained
halted  out  1  halt record captured

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=RUN, FIFO empty, inum=0, out_valid=0, count=0, overflow=0, done=0, halted=0. Record fields are don't-care while out_valid=0.
- Kind encoding, first match wins:
  - reg_write&mem_write -> 4 STU
  - reg_write&mem_read -> 2 LOAD
  - reg_write -> 1 REG
  - halt -> 5 HALT
  - mem_write -> 3 STORE
  - else -> 0 PLAIN (branch/NOP)
- Capture: in RUN, commit_valid=1 produces one record stamped with the current inum; inum increments by 1 (wraps modulo 2^INUM_W). inputs are sampled at the clk edge.
- Push acceptance: push accepted if count<DEPTH, or if count==DEPTH and out_valid&out_ready pop occurs in the same cycle.
- Overflow: if a push is not accepted, the record is dropped, overflow sets and holds until rst, and inum still increments.
- Pop: out_valid&out_ready removes the head. Head fields are registered outputs, stable while out_valid&!out_ready.
- Latency: a record captured at edge N is visible at out_* after edge N when the FIFO was empty (1-cycle).
- Simultaneous push and pop at count==0: push goes through; the record becomes head next cycle.
- Simultaneous push and pop at other occupancies: count unchanged.
- Pointers: rd/wr pointers wrap modulo DEPTH; count tracks full vs empty explicitly.
- State machine:
  - RUN -> DRAIN on capturing a HALT-kind record. A dropped halt still transitions and sets overflow. halted=1 from the next cycle.
  - DRAIN: commit_valid ignored; no capture, no inum change. -> DONE when count==0.
  - DONE: done=1; all inputs except rst ignored; out_valid=0.
- halt with reg_write=1 classifies as REG/LOAD/STU and does not end capture.
- rst asserted mid-operation: FIFO flushed, all state returns to reset values on that edge, in-flight records lost.

Optional Feature:
- Macro: TRACE_CYCLE_STAMP_EN.
- Defined:
  - adds output out_cycle [31:0] and a free-running 32-bit cycle counter: 0 after rst, +1 every cycle, wraps.
  - Each record stores the counter value at its capture edge; out_cycle follows out_valid rules.
- Undefined: no counter, no port; all other behaviour identical.

Test Plan:
- REG/STORE/PLAIN classification: 3 commits (reg_write w/reg 3 data 0x1234; mem_write addr 0x0040 data 0xBEEF; none), out_ready=1 -> kinds 1,3,0, inum 0,1,2, fields match, overflow=0.
- LOAD and STU: reg_write+mem_read addr 0x0100 -> kind 2; reg_write+mem_write reg 5 addr 0x0102 -> kind 4 with out_val, out_addr, out_mdata all set.
- Back-pressure/overflow (DEPTH=8): out_ready=0, 10 commits -> count=8, overflow=1, then drain yields inum 0..7; next commit gets inum 10.
- Full with same-cycle pop: count=8, commit with out_ready=1 -> accepted, count stays 8, overflow stays 0.
- Halt flow:
  - 2 commits then halt=1 with reg_write=0 -> HALT record inum 2, halted=1, later commits ignored.
  - After drain, done=1, out_valid=0.
- Reset mid-run: 4 records buffered, rst for 1 cycle -> count=0, out_valid=0, overflow=0, next record inum 0. With TRACE_CYCLE_STAMP_EN, the first commit 3 cycles after rst carries out_cycle=3.
